// File: rtl/multicycle_controller.sv
`default_nettype none
// multicycle_controller: sequencing FSM and datapath control for a multicycle RV32I core.
// Revision: 1.0
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        Carry,
  input  logic        Referee,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  output logic        retire,
  output logic        illegal_instr,
  output logic [3:0]  state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_EXECU    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t     r_state;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_cond;
  logic [3:0] w_alu_exec;
  logic       w_pcwrite, w_memwrite, w_irwrite, w_regwrite, w_retire, w_illegal;
  logic       w_unused;

  assign w_op     = Instr[6:0];
  assign w_f3     = Instr[14:12];
  assign w_unused = ^{Instr[31], Instr[29:15], Instr[11:7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
            OP_BRANCH:         r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_LUI, OP_AUIPC:  r_state <= S_EXECU;
            default:           r_state <= S_TRAP;
          endcase
        end
        S_MEMADR:   r_state <= w_op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_BRANCH:                r_state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL, S_JLINK, S_EXECU: r_state <= S_ALUWB;
        S_JALR:     r_state <= S_JLINK;
        default:    r_state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    w_cond = 1'b0;
    case (w_f3)
      3'b000:  w_cond = Zero;
      3'b001:  w_cond = ~Zero;
      3'b100:  w_cond = Referee;
      3'b101:  w_cond = ~Referee;
      3'b110:  w_cond = ~Carry;
      3'b111:  w_cond = Carry;
      default: w_cond = 1'b0;
    endcase
  end

  // Only R-type can subtract; I-type bit 30 is part of the immediate.
  always_comb begin
    w_alu_exec = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_exec = (w_op[5] && Instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_exec = ALU_SLL;
      3'b010:  w_alu_exec = ALU_SLT;
      3'b011:  w_alu_exec = ALU_SLTU;
      3'b100:  w_alu_exec = ALU_XOR;
      3'b101:  w_alu_exec = Instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_exec = ALU_OR;
      default: w_alu_exec = ALU_AND;
    endcase
  end

  always_comb begin
    case (w_op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = mem_ready;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = w_alu_exec;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        w_retire   = 1'b1;
        w_pcwrite  = w_cond;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_JLINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_EXECU: begin
        ALUSrcB = 2'b01;
        if (w_op == OP_LUI) ALUControl = ALU_PASSB;
        else                ALUSrcA    = 2'b01;
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  assign PCWrite       = w_pcwrite  & ~reset;
  assign MemWrite      = w_memwrite & ~reset;
  assign IRWrite       = w_irwrite  & ~reset;
  assign RegWrite      = w_regwrite & ~reset;
  assign retire        = w_retire   & ~reset;
  assign illegal_instr = w_illegal  & ~reset;
  assign state         = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I datapath: one shared memory port, one shared ALU, IR/OldPC/A/B/ALUOut/Data holding registers.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select.
- Evaluates branch conditions from the ALU flags.
- Stalls on a memory ready handshake and traps on unsupported opcodes.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- Instr  input  32  current IR contents.
- Zero  input  1  ALU result == 0.
- Carry  input  1  carry out of A-B (1 = A >= B unsigned).
- Referee  input  1  signed A < B.
- mem_ready  input  1  memory completes the access this cycle.
- PCWrite  output  1  PC load enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR/OldPC load enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A.
- ALUSrcB  output  2  00 = B, 01 = ImmExt, 10 = constant 4.
- ALUControl  output  4  operation select.
- ImmSrc  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- retire  output  1  one-cycle pulse in the final cycle of each instruction.
- illegal_instr  output  1  high while in TRAP.
- state  output  4  current state, for debug.

Behaviour:
- State register updates on the rising edge of clk. reset=1 forces state to FETCH on the next edge.
- While reset=1, all strobes are 0 in the same cycle: PCWrite, MemWrite, IRWrite, RegWrite, retire, illegal_instr.
- Outputs are combinational from state, Instr and mem_ready. Every unused mux select is 0.
- ALUControl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT.
  - 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASSB.
- ImmSrc is always decoded from Instr[6:0]; it is 000 for unlisted opcodes.
- States and actions:
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; else go to DECODE.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ImmSrc=B, ADD, so ALUOut = branch target. Dispatch on opcode:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1100011 -> BRANCH.
    - 1101111 -> JAL.
    - 1100111 -> JALR.
    - 0110111 or 0010111 -> EXECU.
    - any other opcode -> TRAP.
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ADD. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD(3): AdrSrc=1, ResultSrc=00. Hold until mem_ready, then go to MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1, retire=1. Go to FETCH.
  - MEMWRITE(5): AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle of the state. retire=mem_ready. Leave to FETCH on mem_ready.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00. Go to ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01. Go to ALUWB.
  - ALU op in EXECR/EXECI, by funct3:
    - 000: ADD, or SUB only when op[5]=1 and Instr[30]=1 (I-type never subtracts).
    - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
    - 101: SRA when Instr[30]=1, else SRL.
    - 110: OR. 111: AND.
  - ALUWB(8): ResultSrc=00, RegWrite=1, retire=1. Go to FETCH.
  - BRANCH(9): ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, retire=1. Go to FETCH. PCWrite=cond, where cond by funct3 is:
    - 000 Zero, 001 ~Zero.
    - 100 Referee, 101 ~Referee.
    - 110 ~Carry, 111 Carry.
    - 010/011: cond=0.
  - JAL(10): ResultSrc=00, PCWrite=1. ALUSrcA=01, ALUSrcB=10, ADD, so ALUOut = OldPC+4. Go to ALUWB. The decode-stage target uses ImmSrc=J for this opcode.
  - JALR(11): ALUSrcA=10, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Go to JLINK.
  - JLINK(12): ALUSrcA=01, ALUSrcB=10, ADD. Go to ALUWB.
  - EXECU(13): ALUSrcB=01, ImmSrc=U. LUI: PASSB. AUIPC: ALUSrcA=01, ADD. Go to ALUWB.
  - TRAP(14): all strobes 0, illegal_instr=1. Left only by reset.
  - Encoding 15 is unreachable; if entered, go to TRAP.
- Latency with mem_ready=1 (cycles): R/I/U/JAL 4, load 5, store 4, branch 3, JALR 5. Each wait cycle adds 1 in FETCH/MEMREAD/MEMWRITE.
- Reset asserted mid-instruction, including during a MEMWRITE wait, forces all strobes 0 that cycle and returns to FETCH. No partial writeback occurs.

Test Plan:
- reset=1 for 2 cycles, release, mem_ready=1 -> state=0 during reset with all strobes 0. First FETCH asserts IRWrite=PCWrite=1.
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> state sequence 0,1,6,8. In state 6, ALUControl=0000. RegWrite=retire=1 only in state 8.
- sub (0x402081B3) -> ALUControl=0001 in EXECR. srai (0x4020D193) -> 1001. addi with Instr[30]=1 -> 0000.
- beq with Zero=1 -> PCWrite=1 in BRANCH, total 3 cycles. bltu with Carry=1 -> PCWrite=0. bge with Referee=0 -> PCWrite=1.
- sw (0x0020A223), mem_ready low for 3 cycles in MEMWRITE -> MemWrite held high 4 cycles, retire only on the ready cycle. lw with mem_ready=1 -> 5 cycles, ResultSrc=01 at writeback. Reset pulsed during the MEMWRITE wait -> MemWrite=0 that cycle, then FETCH.
- jalr (0x000080E7) -> sequence 0,1,11,12,8 with PCWrite=1 only in 11. Opcode 0x0000007F -> TRAP, illegal_instr=1 until reset, no strobes.
